// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program bytes over a ready/valid port
// and presents them to the control unit. Define FETCH_PREFETCH_EN for a 2-entry buffer.
module fetch_unit #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              pcc,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    output logic [7:0]        ir_data,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_rd_q;
    logic              ir_valid_q;
    logic [7:0]        head_q, head_d;
`ifdef FETCH_PREFETCH_EN
    logic [7:0]        tail_q, tail_d;
`endif
    logic [1:0]        cnt_q, cnt_d;
    logic              push_s, pop_s, free_s;

    // Jump dominates: it cancels both the capture and the pop of the current cycle.
    always_comb begin
        push_s = (state_q == REQ) && mem_ready && !jmp;
        pop_s  = pcc && (cnt_q != 2'd0) && !jmp;
    end

`ifdef FETCH_PREFETCH_EN
    // Two-entry buffer: head is presented, tail holds the prefetched byte.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (jmp) begin
            head_d = 8'h00;
            tail_d = 8'h00;
            cnt_d  = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_d = mem_data;
                    end else begin
                        tail_d = mem_data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = mem_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = mem_data;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end
`else
    // Single-entry buffer: the presented byte is the only storage.
    always_comb begin
        head_d = head_q;
        cnt_d  = cnt_q;
        if (jmp) begin
            head_d = 8'h00;
            cnt_d  = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   begin head_d = mem_data; cnt_d = 2'd1; end
                2'b01:   begin cnt_d = 2'd0; end
                2'b11:   begin head_d = mem_data; end
                default: begin cnt_d = cnt_q; end
            endcase
        end
    end
`endif

    // Free-slot decisions look at post-update occupancy so a pop re-arms REQ at once.
    always_comb begin
        free_s  = (cnt_d < DEPTH);
        state_d = state_q;
        pc_d    = pc_q;
        if (jmp) begin
            pc_d    = jmp_addr;
            state_d = halt ? IDLE : REQ;
        end else begin
            if (push_s) begin
                pc_d = pc_q + PC_ONE;
            end else begin
                pc_d = pc_q;
            end
            case (state_q)
                IDLE: begin
                    if (!halt && free_s) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (!mem_ready) begin
                        state_d = REQ;
                    end else if (!halt && free_s) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!halt && free_s) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, PC, buffer and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RST_PC;
            mem_rd_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            head_q     <= 8'h00;
`ifdef FETCH_PREFETCH_EN
            tail_q     <= 8'h00;
`endif
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_rd_q   <= (state_d == REQ);
            ir_valid_q <= (cnt_d != 2'd0);
            head_q     <= head_d;
`ifdef FETCH_PREFETCH_EN
            tail_q     <= tail_d;
`endif
            cnt_q      <= cnt_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir_data  = head_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, wait states, jump flush, wrap/halt, async reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, halt, pcc, jmp;
    logic [15:0] jmp_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [7:0]  ir_data;
    logic        ir_valid;
    logic [15:0] pc;

    logic        auto_rdy, rdy_man;
    logic [1:0]  data_sel;
    logic [7:0]  data_man;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory model: zero-wait (ready follows mem_rd) or manually driven ready.
    assign mem_ready = auto_rdy ? mem_rd : rdy_man;
    assign mem_data  = (data_sel == 2'd2) ? data_man :
                       (data_sel == 2'd1) ? {mem_addr[3:0], mem_addr[3:0]} : mem_addr[7:0];

    fetch_unit #(.ADDR_W(16), .RESET_VEC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .pcc(pcc), .jmp(jmp), .jmp_addr(jmp_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .ir_data(ir_data), .ir_valid(ir_valid), .pc(pc)
    );

    task automatic do_jump(input logic [15:0] a);
        jmp = 1'b1; jmp_addr = a;
        @(negedge clk);
        jmp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; pcc = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000;
        auto_rdy = 1'b1; rdy_man = 1'b0; data_sel = 2'd0; data_man = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        n_cmp++; if (pc !== 16'h0100) begin n_err++; $display("FAIL rst_pc: got %h want 0100", pc); end
        n_cmp++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0100", mem_addr); end
        n_cmp++; if (ir_data !== 8'h00) begin n_err++; $display("FAIL rst_ir_data: got %h want 00", ir_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL rel_c1_mem_rd: got %b want 1", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL rel_c1_addr: got %h want 0100", mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rel_c1_valid: got %b want 0", ir_valid); end
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL rel_c2_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir_data !== 8'h00) begin n_err++; $display("FAIL rel_c2_data: got %h want 00", ir_data); end
        n_cmp++; if (pc !== 16'h0101) begin n_err++; $display("FAIL rel_c2_pc: got %h want 0101", pc); end
    endtask

    task automatic test_stream();
        logic [7:0] bytes [3];
        logic [7:0] exp_b [3];
        int got, gaps, exp_gaps;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
`ifdef FETCH_PREFETCH_EN
        exp_gaps = 0;
`else
        exp_gaps = 2;
`endif
        got = 0; gaps = 0;
        bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'h00;
        data_sel = 2'd1; auto_rdy = 1'b1;
        do_jump(16'h0001);
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (ir_valid) begin
                bytes[got] = ir_data; got++; pcc = 1'b1;
            end else begin
                if (got > 0) gaps++;
                pcc = 1'b0;
            end
            @(negedge clk);
        end
        pcc = 1'b0;
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL stream_timeout: got %0d bytes want 3", got); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bytes[i] !== exp_b[i]) begin n_err++; $display("FAIL stream_byte%0d: got %h want %h", i, bytes[i], exp_b[i]); end
        end
        n_cmp++; if (gaps !== exp_gaps) begin n_err++; $display("FAIL stream_gaps: got %0d want %0d", gaps, exp_gaps); end
    endtask

    task automatic test_wait_states();
        auto_rdy = 1'b0; rdy_man = 1'b0; data_sel = 2'd0; pcc = 1'b0;
        do_jump(16'h0345);
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL wait_rd_c%0d: got %b want 1", c, mem_rd); end
            n_cmp++; if (mem_addr !== 16'h0345) begin n_err++; $display("FAIL wait_addr_c%0d: got %h want 0345", c, mem_addr); end
            n_cmp++; if (pc !== 16'h0345) begin n_err++; $display("FAIL wait_pc_c%0d: got %h want 0345", c, pc); end
            pcc = (c < 3);
            rdy_man = (c == 3);
            @(negedge clk);
        end
        rdy_man = 1'b0; pcc = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir_data !== 8'h45) begin n_err++; $display("FAIL wait_data: got %h want 45", ir_data); end
        n_cmp++; if (pc !== 16'h0346) begin n_err++; $display("FAIL wait_pc_inc: got %h want 0346", pc); end
        @(negedge clk);
        n_cmp++; if (pc !== 16'h0346) begin n_err++; $display("FAIL wait_pc_once: got %h want 0346", pc); end
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL wait_hold_valid: got %b want 1", ir_valid); end
    endtask

    task automatic test_jump_flush();
        auto_rdy = 1'b0; rdy_man = 1'b0; data_sel = 2'd2; data_man = 8'hAA;
        do_jump(16'h0400);
        n_cmp++; if (mem_addr !== 16'h0400) begin n_err++; $display("FAIL jmp_pend_addr: got %h want 0400", mem_addr); end
        rdy_man = 1'b1; jmp = 1'b1; jmp_addr = 16'h2000;
        @(negedge clk);
        jmp = 1'b0; rdy_man = 1'b0; data_man = 8'h5C;
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL jmp_valid0: got %b want 0", ir_valid); end
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL jmp_rd: got %b want 1", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h2000) begin n_err++; $display("FAIL jmp_addr: got %h want 2000", mem_addr); end
        n_cmp++; if (pc !== 16'h2000) begin n_err++; $display("FAIL jmp_pc: got %h want 2000", pc); end
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL jmp_valid1: got %b want 0", ir_valid); end
        rdy_man = 1'b1;
        @(negedge clk);
        rdy_man = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL jmp_new_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir_data !== 8'h5C) begin n_err++; $display("FAIL jmp_new_data: got %h want 5c", ir_data); end
        n_cmp++; if (pc !== 16'h2001) begin n_err++; $display("FAIL jmp_new_pc: got %h want 2001", pc); end
    endtask

    task automatic test_wrap_halt();
        auto_rdy = 1'b1; data_sel = 2'd0; halt = 1'b0; pcc = 1'b0;
        do_jump(16'hFFFF);
        n_cmp++; if (mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr: got %h want ffff", mem_addr); end
        halt = 1'b1;
        @(negedge clk);
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd0: got %b want 0", mem_rd); end
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL halt_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir_data !== 8'hFF) begin n_err++; $display("FAIL halt_data: got %h want ff", ir_data); end
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd1: got %b want 0", mem_rd); end
        n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL halt_keep: got %b want 1", ir_valid); end
        pcc = 1'b1;
        @(negedge clk);
        pcc = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL halt_pop: got %b want 0", ir_valid); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd2: got %b want 0", mem_rd); end
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd3: got %b want 0", mem_rd); end
        halt = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL resume_rd: got %b want 1", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL resume_addr: got %h want 0000", mem_addr); end
    endtask

    task automatic test_async_reset();
        auto_rdy = 1'b0; rdy_man = 1'b0; halt = 1'b0; pcc = 1'b0;
        do_jump(16'h0500);
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL ares_pre_rd: got %b want 1", mem_rd); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL ares_rd: got %b want 0", mem_rd); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL ares_valid: got %b want 0", ir_valid); end
        n_cmp++; if (pc !== 16'h0100) begin n_err++; $display("FAIL ares_pc: got %h want 0100", pc); end
        rdy_man = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL stray_valid: got %b want 0", ir_valid); end
        n_cmp++; if (pc !== 16'h0100) begin n_err++; $display("FAIL stray_pc: got %h want 0100", pc); end
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL stray_rd: got %b want 1", mem_rd); end
        rdy_man = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_jump_flush();
        test_wrap_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the program counter and sequences byte reads from external program memory over a ready/valid handshake.
- Presents each fetched byte to the control unit as ir_data/ir_valid. The control unit's pcc strobe acknowledges (consumes) the presented byte.
- Handles jumps: loads a new PC and flushes any fetched-but-unconsumed bytes.

Parameters:
- ADDR_W, 16, program counter and memory address width in bits.
- RESET_VEC, 0, PC value loaded on reset, truncated to ADDR_W bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halt  input  1  when 1, no new memory request is issued.
- pcc  input  1  consume strobe from control unit; pops the presented byte.
- jmp  input  1  load PC from jmp_addr and flush.
- jmp_addr  input  ADDR_W  jump target.
- mem_rd  output  1  read request to program memory.
- mem_addr  output  ADDR_W  read address; stable while mem_rd=1.
- mem_ready  input  1  memory has returned mem_data this cycle.
- mem_data  input  8  read data; sampled only when mem_rd & mem_ready.
- ir_data  output  8  byte presented to control unit.
- ir_valid  output  1  ir_data is valid (drives control unit iri_in).
- pc  output  ADDR_W  address of the next byte to be requested.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_VEC, mem_rd=0, mem_addr=RESET_VEC, ir_data=0, ir_valid=0, FSM=IDLE, buffer empty.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - Go to REQ next cycle if halt=0 and the buffer has a free slot.
- REQ:
  - mem_rd=1, mem_addr=pc.
  - On mem_ready=1: capture mem_data into the buffer tail and set pc<=pc+1 (mod 2^ADDR_W; all-ones wraps to 0).
  - Next state: REQ if the buffer still has a free slot and halt=0; else HOLD.
  - mem_rd is held continuously until mem_ready; the request is never withdrawn except by jmp.
- HOLD:
  - mem_rd=0.
  - Return to REQ the cycle after a slot frees (pcc pop) and halt=0.
- Buffer depth: 1 without PREFETCH_EN, 2 with it.
  - ir_valid = buffer non-empty; ir_data = buffer head (registered).
- Consume:
  - pcc=1 with ir_valid=1: head pops at the clock edge.
  - pcc=1 with ir_valid=0: ignored, no state change.
  - Capture and pop in the same cycle is legal: occupancy is unchanged and the new byte moves to the correct position.
- Latency: first byte is presented (ir_valid=1) on the cycle after the mem_ready capture. Minimum REQ-to-ir_valid is 2 cycles with zero-wait memory.
- Jump (highest priority, any state):
  - pc<=jmp_addr, buffer cleared, ir_valid=0 next cycle, FSM to REQ (or IDLE if halt=1).
  - mem_ready in the same cycle as jmp: data discarded, pc not incremented.
  - pcc in the same cycle as jmp: ignored.
- Halt:
  - Blocks new requests only.
  - An outstanding REQ completes.
  - The buffer stays presentable and consumable.
- Reset mid-transaction: everything returns to reset values immediately; late mem_ready arriving while in IDLE is ignored.
- pc output always equals the address of the next request (= mem_addr whenever mem_rd=1).

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined: 2-entry buffer. The unit keeps fetching while the control unit holds the current byte, so back-to-back pcc strobes see ir_valid continuously with zero-wait memory.
- Undefined: 1-entry buffer. The next request issues only after the pop, giving a 1-cycle ir_valid bubble between bytes.
- Jump/flush clears all entries in both builds.

Test Plan:
- Reset release, RESET_VEC=0x0100, zero-wait memory returning addr[7:0]:
  - mem_rd=1 with mem_addr=0x0100 on cycle 1 after release.
  - ir_valid=1, ir_data=0x00 on cycle 2.
  - pc=0x0101.
- Streaming, pcc asserted every cycle ir_valid=1, memory returns 0x11,0x22,0x33:
  - Bytes are consumed in order with no loss or duplication.
  - With FETCH_PREFETCH_EN, ir_valid stays high after the first byte.
  - Without it, ir_valid is low for one cycle between bytes.
- Wait states, mem_ready delayed 3 cycles:
  - mem_addr is stable and mem_rd=1 for all 4 cycles.
  - pc increments exactly once.
- Jump during pending read: jmp=1, jmp_addr=0x2000 in the same cycle as mem_ready with data 0xAA:
  - 0xAA is never presented.
  - Next request uses mem_addr=0x2000.
  - ir_valid=0 until that byte returns.
- Wrap and halt:
  - pc=0xFFFF fetch leads to pc=0x0000.
  - halt=1 during HOLD: no mem_rd; the buffered byte is still consumable via pcc.
  - halt=0 resumes the request at 0x0000.
- Async reset mid-REQ:
  - rst_n low between clock edges gives mem_rd=0 and ir_valid=0 immediately.
  - A subsequent stray mem_ready is ignored.
